seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a common-anode multi-digit 7-segment display. It generalises the single-digit BCD decoder to `DIGITS` channels and adds several features:
- per-digit scan with anti-ghosting dead time
- hexadecimal mode
- leading-zero blanking
- per-digit decimal point, blanking and blinking

It sits between the lock's datapath (code entry and countdown registers) and the board's segment and digit-select pins.

---
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: per-digit scan with dead time,
// frame snapshot of all inputs, hex mode, leading-zero blanking, dp, blank and blink.
//
//   state  | meaning
//   S_DARK | after reset, nothing selected until the first scan wrap
//   S_LOAD | dead time, digit select off, segment pattern loads next edge
//   S_ARM  | pattern loaded, digit select asserts next edge
//   S_SHOW | current digit lit until the next scan wrap
module seg7_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic [DIGITS-1:0]     blink_in,
   input  logic                  hex_mode,
   input  logic                  lzb_en,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic [1:0] {S_DARK, S_LOAD, S_ARM, S_SHOW} state_t;

   state_t                state_q;
   logic [CW-1:0]         scan_cnt_q;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_d;
   logic [FW-1:0]         frame_cnt_q;
   logic                  blink_ph_q;
   logic [4*DIGITS-1:0]   snap_bcd_q;
   logic [DIGITS-1:0]     snap_dp_q;
   logic [DIGITS-1:0]     snap_blank_q;
   logic [DIGITS-1:0]     snap_blink_q;
   logic                  snap_hex_q;
   logic                  snap_lzb_q;
   logic [7:0]            seg_q;
   logic [DIGITS-1:0]     dig_sel_q;
   logic                  frame_tick_q;

   logic                  scan_wrap;
   logic                  frame_start;
   logic [3:0]            cur_val;
   logic                  lead_zero;
   logic                  lzb_act;
   logic [6:0]            enc;
   logic [7:0]            pat_d;

   assign scan_wrap   = (scan_cnt_q == CW'(SCAN_DIV - 1));
   assign idx_d       = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
   assign frame_start = scan_wrap && (idx_d == '0);

   always_comb begin
      cur_val   = snap_bcd_q[4*idx_q +: 4];
      lead_zero = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if (j >= int'(idx_q) && snap_bcd_q[4*j +: 4] != 4'd0) lead_zero = 1'b0;
      end
      lzb_act = snap_lzb_q && (idx_q != '0) && lead_zero;

      unique case (cur_val)
         4'h0: enc = 7'h40;
         4'h1: enc = 7'h79;
         4'h2: enc = 7'h24;
         4'h3: enc = 7'h30;
         4'h4: enc = 7'h19;
         4'h5: enc = 7'h12;
         4'h6: enc = 7'h02;
         4'h7: enc = 7'h78;
         4'h8: enc = 7'h00;
         4'h9: enc = 7'h10;
         4'hA: enc = 7'h08;
         4'hB: enc = 7'h03;
         4'hC: enc = 7'h46;
         4'hD: enc = 7'h21;
         4'hE: enc = 7'h06;
         default: enc = 7'h0E;
      endcase
      if (cur_val > 4'd9 && !snap_hex_q) enc = 7'h7F;

      if (snap_blank_q[idx_q])                    pat_d = 8'hFF;
      else if (snap_blink_q[idx_q] && blink_ph_q) pat_d = 8'hFF;
      else if (lzb_act)                           pat_d = {~snap_dp_q[idx_q], 7'h7F};
      else                                        pat_d = {~snap_dp_q[idx_q], enc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_DARK;
         scan_cnt_q   <= '0;
         idx_q        <= IW'(DIGITS - 1);
         frame_cnt_q  <= '0;
         blink_ph_q   <= 1'b0;
         snap_bcd_q   <= '0;
         snap_dp_q    <= '0;
         snap_blank_q <= '0;
         snap_blink_q <= '0;
         snap_hex_q   <= 1'b0;
         snap_lzb_q   <= 1'b0;
         seg_q        <= 8'hFF;
         dig_sel_q    <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         scan_cnt_q   <= scan_wrap ? '0 : scan_cnt_q + CW'(1);
         frame_tick_q <= frame_start;
         if (scan_wrap) begin
            idx_q     <= idx_d;
            dig_sel_q <= '1;
            state_q   <= S_LOAD;
            if (frame_start) begin
               snap_bcd_q   <= bcd_in;
               snap_dp_q    <= dp_in;
               snap_blank_q <= blank_in;
               snap_blink_q <= blink_in;
               snap_hex_q   <= hex_mode;
               snap_lzb_q   <= lzb_en;
               if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                  frame_cnt_q <= '0;
                  blink_ph_q  <= ~blink_ph_q;
               end else begin
                  frame_cnt_q <= frame_cnt_q + FW'(1);
               end
            end
         end else begin
            unique case (state_q)
               S_LOAD: begin
                  seg_q   <= pat_d;
                  state_q <= S_ARM;
               end
               S_ARM: begin
                  dig_sel_q <= ~(DIGITS'(1) << idx_q);
                  state_q   <= S_SHOW;
               end
               default: ;
            endcase
         end
      end
   end

   assign seg_out    = seg_q;
   assign dig_sel    = dig_sel_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-arithmetic reference model checked every cycle,
// plus directed frame captures against fixed segment codes.
module tb_seg7_scan_driver;

   localparam int D  = 4;
   localparam int SD = 4;
   localparam int BF = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [4*D-1:0] bcd_in = '0;
   logic [D-1:0]   dp_in = '0, blank_in = '0, blink_in = '0;
   logic           hex_mode = 1'b0, lzb_en = 1'b0;
   logic [7:0]     seg_out;
   logic [D-1:0]   dig_sel;
   logic           frame_tick;

   int n_chk = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .blank_in(blank_in),
      .blink_in(blink_in), .hex_mode(hex_mode), .lzb_en(lzb_en),
      .seg_out(seg_out), .dig_sel(dig_sel), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [7:0] ref_pat(input int i, input logic [4*D-1:0] b,
         input logic [D-1:0] dp, input logic [D-1:0] bl, input logic [D-1:0] bk,
         input logic hx, input logic lz, input logic ph);
      logic [7:0] tbl [16];
      logic [3:0] v;
      logic [6:0] s;
      tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      v = b[4*i +: 4];
      if (bl[i]) return 8'hFF;
      if (bk[i] && ph) return 8'hFF;
      if (lz && i > 0 && (b >> (4*i)) == 0) s = 7'h7F;
      else if (v > 9 && !hx) s = 7'h7F;
      else s = tbl[v][6:0];
      return {~dp[i], s};
   endfunction

   // reference: n = clock edges since reset release; every SD-th edge is a digit change
   int             m_n;
   int             m_f;
   logic [4*D-1:0] m_b;
   logic [D-1:0]   m_dp, m_bl, m_bk;
   logic           m_hx, m_lz;
   logic [7:0]     m_seg;

   function automatic int m_idx();
      if (m_n / SD == 0) return -1;
      return (m_n / SD - 1) % D;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_f = 0; m_seg = 8'hFF;
         m_b = '0; m_dp = '0; m_bl = '0; m_bk = '0; m_hx = 0; m_lz = 0;
      end else begin
         m_n++;
         if (m_idx() == 0 && m_n % SD == 0) begin
            m_f++;
            m_b = bcd_in; m_dp = dp_in; m_bl = blank_in; m_bk = blink_in;
            m_hx = hex_mode; m_lz = lzb_en;
         end
         if (m_idx() >= 0 && m_n % SD == 1)
            m_seg = ref_pat(m_idx(), m_b, m_dp, m_bl, m_bk, m_hx, m_lz, 1'((m_f / BF) % 2));
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         int i;
         logic [D-1:0] ed;
         i  = m_idx();
         ed = (i >= 0 && m_n % SD >= 2) ? ~(D'(1) << i) : '1;
         chk("tick", frame_tick, (i == 0 && m_n % SD == 0));
         chk("dig", dig_sel, ed);
         chk("seg", seg_out, m_seg);
      end
   end

   logic [7:0] obs [8][D];

   task automatic set_in(input logic [4*D-1:0] b, input logic [D-1:0] dp,
         input logic [D-1:0] bl, input logic [D-1:0] bk, input logic hx, input logic lz);
      @(negedge clk);
      bcd_in = b; dp_in = dp; blank_in = bl; blink_in = bk; hex_mode = hx; lzb_en = lz;
   endtask

   task automatic grab_frames(input int nf);
      int w = 0;
      for (int f = 0; f < 8; f++) for (int i = 0; i < D; i++) obs[f][i] = 8'h00;
      do begin
         @(negedge clk);
         w++;
      end while (!frame_tick && w < 4*D*SD);
      if (!frame_tick) chk("tick_timeout", 0, 1);
      for (int c = 0; c < nf*D*SD; c++) begin
         @(negedge clk);
         for (int i = 0; i < D; i++)
            if (dig_sel == ~(D'(1) << i)) obs[c / (D*SD)][i] = seg_out;
      end
   endtask

   task automatic frame_is(input string tag, input logic [31:0] exp);
      chk(tag, {obs[0][3], obs[0][2], obs[0][1], obs[0][0]}, exp);
   endtask

   initial begin
      int c, on, off;
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, on, off;
      bcd_in = 16'h0001;
      repeat (3) @(negedge clk);
      chk("rst_seg", seg_out, 8'hFF);
      chk("rst_dig", dig_sel, 4'b1111);
      chk("rst_tick", frame_tick, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!frame_tick && c < 20);
      chk("first_tick_cycles", c, SD);
      repeat (2) @(negedge clk);
      chk("first_dig", dig_sel, 4'b1110);
      chk("first_seg", seg_out, 8'hF9);

      set_in(16'h1234, 4'b0010, 0, 0, 0, 0);  grab_frames(1); frame_is("scan_1234", 32'hF9A43099);
      set_in(16'h0007, 0, 0, 0, 0, 1);        grab_frames(1); frame_is("lzb_0007", 32'hFFFFFFF8);
      set_in(16'h0007, 0, 0, 0, 0, 0);        grab_frames(1); frame_is("nolzb_0007", 32'hC0C0C0F8);
      set_in(16'h0000, 0, 0, 0, 0, 1);        grab_frames(1); frame_is("lzb_0000", 32'hFFFFFFC0);
      set_in(16'hABCD, 0, 0, 0, 1, 0);        grab_frames(1); frame_is("hex_on", 32'h8883C6A1);
      set_in(16'hABCD, 0, 0, 0, 0, 0);        grab_frames(1); frame_is("hex_off", 32'hFFFFFFFF);
      set_in(16'hABCD, 4'b1111, 0, 0, 0, 0);  grab_frames(1); frame_is("hex_off_dp", 32'h7F7F7F7F);

      set_in(16'h0008, 0, 0, 4'b0001, 0, 0);
      grab_frames(4);
      on = 0; off = 0;
      for (int f = 0; f < 4; f++) begin
         if (obs[f][0] == 8'h80) on++;
         if (obs[f][0] == 8'hFF) off++;
      end
      chk("blink_on_frames", on, 2);
      chk("blink_off_frames", off, 2);
      set_in(16'h0008, 4'b0001, 4'b0001, 4'b0001, 0, 0);
      grab_frames(4);
      off = 0;
      for (int f = 0; f < 4; f++) if (obs[f][0] == 8'hFF) off++;
      chk("blank_frames", off, 4);

      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) begin
            for (int i = 0; i < D; i++)
               bcd_in[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dp_in    = D'($urandom);
            blank_in = D'($urandom) & D'($urandom);
            blink_in = D'($urandom);
            hex_mode = 1'($urandom);
            lzb_en   = 1'($urandom);
         end
      end

      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(m_idx() == 1 && m_n % SD == 2) && c < 40);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_seg", seg_out, 8'hFF);
      chk("midrst_dig", dig_sel, 4'b1111);
      chk("midrst_tick", frame_tick, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (dig_sel == 4'b1111 && c < 40);
      chk("restart_sel_cycles", c, SD + 2);
      repeat (3 * D * SD) @(negedge clk);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
